// File: rtl/xc20xx_cfg_loader_if.sv
// xc20xx_cfg_loader_if: serial bitstream in, per-CLB config words out
interface xc20xx_cfg_loader_if #(
  parameter int CFG_W = 36,
  parameter int LEN_W = 8
);
  logic din;
  logic din_en;
  logic [CFG_W-1:0] cfg_data;
  logic [LEN_W-1:0] cfg_addr;
  logic cfg_valid;
  logic busy;
  logic done;
  logic err;
  modport master (output din, din_en, input cfg_data, cfg_addr, cfg_valid, busy, done, err);
  modport slave (input din, din_en, output cfg_data, cfg_addr, cfg_valid, busy, done, err);
endinterface

// File: rtl/xc20xx_cfg_loader.sv
// xc20xx_cfg_loader: deframes preamble/sync/length/data/stop and emits one config word per frame
module xc20xx_cfg_loader #(
  parameter int CFG_W = 36,
  parameter int LEN_W = 8,
  parameter logic [3:0] SYNC = 4'b0010
) (
  input logic K,
  input logic RST,
  xc20xx_cfg_loader_if.slave bus
);
  localparam int CNT_W = $clog2(CFG_W + LEN_W + 4);
  typedef enum logic [2:0] {IDLE, SYN, LEN, DATA, STOP, DONE_S, ERROR} state_t;
  state_t state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [LEN_W-1:0] n_q, n_d, frame_q, cfg_addr_q;
  logic [CFG_W-1:0] shift_q, shift_d, cfg_data_q;
  logic valid_q, busy_q, done_q, err_q;
  always_comb begin
    n_d = {bus.din, n_q[LEN_W-1:1]};
    shift_d = {bus.din, shift_q[CFG_W-1:1]};
  end
  always_ff @(posedge K) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q <= '0;
      n_q <= '0;
      frame_q <= '0;
      shift_q <= '0;
      cfg_data_q <= '0;
      cfg_addr_q <= '0;
      valid_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (bus.din_en) begin
        case (state_q)
          IDLE: if (!bus.din) begin
            state_q <= SYN;
            cnt_q <= CNT_W'(1);
            busy_q <= 1'b1;
          end
          SYN: if (bus.din != SYNC[2'd3 - cnt_q[1:0]]) begin
            state_q <= ERROR;
            err_q <= 1'b1;
            busy_q <= 1'b0;
          end else if (cnt_q == CNT_W'(3)) begin
            state_q <= LEN;
            cnt_q <= '0;
          end else cnt_q <= cnt_q + CNT_W'(1);
          LEN: begin
            n_q <= n_d;
            cnt_q <= cnt_q == CNT_W'(LEN_W - 1) ? '0 : cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(LEN_W - 1)) begin
              state_q <= n_d == '0 ? DONE_S : DATA;
              done_q <= n_d == '0;
              busy_q <= n_d != '0;
              frame_q <= '0;
            end
          end
          DATA: begin
            shift_q <= shift_d;
            cnt_q <= cnt_q == CNT_W'(CFG_W - 1) ? '0 : cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(CFG_W - 1)) state_q <= STOP;
          end
          // a frame is only published once both stop bits are good
          STOP: if (!bus.din) begin
            state_q <= ERROR;
            err_q <= 1'b1;
            busy_q <= 1'b0;
          end else if (cnt_q == '0) cnt_q <= CNT_W'(1);
          else begin
            cnt_q <= '0;
            cfg_data_q <= shift_q;
            cfg_addr_q <= frame_q;
            valid_q <= 1'b1;
            if (frame_q + LEN_W'(1) == n_q) begin
              state_q <= DONE_S;
              done_q <= 1'b1;
              busy_q <= 1'b0;
            end else begin
              frame_q <= frame_q + LEN_W'(1);
              state_q <= DATA;
            end
          end
          default: ;
        endcase
      end
    end
  end
  assign bus.cfg_data = cfg_data_q;
  assign bus.cfg_addr = cfg_addr_q;
  assign bus.cfg_valid = valid_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.err = err_q;
endmodule

// File: tb/tb_xc20xx_cfg_loader.sv
// tb_xc20xx_cfg_loader: directed stimulus for the config loader with immediate-assertion checks
module tb_xc20xx_cfg_loader;
  logic K = 1'b0;
  logic RST = 1'b1;
  bit gap = 1'b0;
  int total = 0;
  int passed = 0;
  int pulses = 0;
  int p0;
  logic [35:0] got_data[$];
  logic [7:0] got_addr[$];
  xc20xx_cfg_loader_if bus ();
  xc20xx_cfg_loader dut (.K(K), .RST(RST), .bus(bus));
  always #5 K = ~K;
  always @(negedge K) if (bus.cfg_valid) begin
    pulses++;
    got_data.push_back(bus.cfg_data);
    got_addr.push_back(bus.cfg_addr);
  end
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask
  task automatic tick();
    @(posedge K);
    #1;
  endtask
  task automatic send(input logic b);
    bus.din = b;
    bus.din_en = 1'b1;
    tick();
    if (gap) begin
      bus.din_en = 1'b0;
      bus.din = ~b;
      tick();
    end
  endtask
  task automatic send_v(input logic [63:0] v, input int n);
    for (int i = 0; i < n; i++) send(v[i]);
  endtask
  task automatic header(input logic [7:0] n);
    send_v(64'h4F, 8);
    send_v({56'h0, n}, 8);
  endtask
  task automatic frame(input logic [35:0] d, input logic s0, input logic s1);
    send_v({28'h0, d}, 36);
    send(s0);
    send(s1);
  endtask
  task automatic do_reset();
    RST = 1'b1;
    bus.din_en = 1'b0;
    bus.din = 1'b0;
    tick();
    RST = 1'b0;
  endtask
  initial begin
    bus.din = 1'b0;
    bus.din_en = 1'b0;
    // 1) single frame
    do_reset();
    chk("rst_data", bus.cfg_data, 0);
    chk("rst_addr", bus.cfg_addr, 0);
    chk("rst_valid", bus.cfg_valid, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_err", bus.err, 0);
    send_v(64'hF, 4);
    chk("t1_pre_busy", bus.busy, 0);
    send(1'b0);
    chk("t1_sync_busy", bus.busy, 1);
    send_v(64'h2, 3);
    send_v(64'h1, 8);
    chk("t1_len_busy", bus.busy, 1);
    p0 = pulses;
    frame(36'h0A5C30F1E, 1'b1, 1'b1);
    chk("t1_valid", bus.cfg_valid, 1);
    chk("t1_data", bus.cfg_data, 36'h0A5C30F1E);
    chk("t1_addr", bus.cfg_addr, 0);
    chk("t1_done", bus.done, 1);
    chk("t1_err", bus.err, 0);
    chk("t1_busy", bus.busy, 0);
    tick();
    chk("t1_valid_drop", bus.cfg_valid, 0);
    chk("t1_pulses", pulses - p0, 1);
    // 2) three frames, DIN_EN toggling
    do_reset();
    gap = 1'b1;
    p0 = pulses;
    header(8'd3);
    frame(36'h1, 1'b1, 1'b1);
    frame(36'h2, 1'b1, 1'b1);
    chk("t2_done_early", bus.done, 0);
    chk("t2_busy_mid", bus.busy, 1);
    frame(36'hFFFFFFFFF, 1'b1, 1'b1);
    gap = 1'b0;
    chk("t2_done", bus.done, 1);
    chk("t2_pulses", pulses - p0, 3);
    if (pulses - p0 == 3) begin
      chk("t2_a0", got_addr[p0], 0);
      chk("t2_d0", got_data[p0], 36'h1);
      chk("t2_a1", got_addr[p0 + 1], 1);
      chk("t2_d1", got_data[p0 + 1], 36'h2);
      chk("t2_a2", got_addr[p0 + 2], 2);
      chk("t2_d2", got_data[p0 + 2], 36'hFFFFFFFFF);
    end
    // 3) sync mismatch
    do_reset();
    p0 = pulses;
    send_v(64'hCF, 8);
    chk("t3_err", bus.err, 1);
    chk("t3_busy", bus.busy, 0);
    send_v(64'h4F, 8);
    send_v(64'h1, 8);
    send_v(64'h3, 40);
    chk("t3_err_hold", bus.err, 1);
    chk("t3_done", bus.done, 0);
    chk("t3_pulses", pulses - p0, 0);
    // 4) bad stop bits on frame 1
    do_reset();
    p0 = pulses;
    header(8'd2);
    frame(36'h123, 1'b1, 1'b1);
    frame(36'h456, 1'b1, 1'b0);
    chk("t4_err", bus.err, 1);
    chk("t4_done", bus.done, 0);
    chk("t4_data", bus.cfg_data, 36'h123);
    chk("t4_addr", bus.cfg_addr, 0);
    chk("t4_pulses", pulses - p0, 1);
    // 5) zero frames
    do_reset();
    p0 = pulses;
    send_v(64'h4F, 8);
    send_v(64'h0, 7);
    chk("t5_done_pre", bus.done, 0);
    send(1'b0);
    chk("t5_done", bus.done, 1);
    chk("t5_busy", bus.busy, 0);
    tick();
    chk("t5_pulses", pulses - p0, 0);
    // 6) reset mid-frame, then a fresh single-frame stream
    do_reset();
    header(8'd3);
    frame(36'h777, 1'b1, 1'b1);
    send_v(64'h3FF, 10);
    bus.din_en = 1'b1;
    bus.din = 1'b1;
    RST = 1'b1;
    tick();
    chk("t6_data", bus.cfg_data, 0);
    chk("t6_addr", bus.cfg_addr, 0);
    chk("t6_busy", bus.busy, 0);
    chk("t6_valid", bus.cfg_valid, 0);
    RST = 1'b0;
    p0 = pulses;
    header(8'd1);
    frame(36'h9ABCDE12, 1'b1, 1'b1);
    chk("t6_valid2", bus.cfg_valid, 1);
    chk("t6_addr2", bus.cfg_addr, 0);
    chk("t6_data2", bus.cfg_data, 36'h9ABCDE12);
    chk("t6_done", bus.done, 1);
    tick();
    chk("t6_pulses", pulses - p0, 1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
